// File: rtl/dmem_responder.sv
// dmem_responder: word data memory with configurable read latency, a one-entry
// posted write buffer, read forwarding from that buffer, and a pipeline stall.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wd,
    output logic [31:0] o_rd,
    output logic        o_ready,
    output logic        o_stall,
    output logic        o_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] W = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, RBUSY, RRESP} state_t;

    state_t        r_state, w_next;
    logic [3:0]    r_cnt, r_wb_cnt;
    logic [AW-1:0] r_ridx, r_wb_idx, w_idx, w_cap_idx;
    logic [31:0]   r_wb_data, r_rd;
    logic          r_wb_valid, r_err;
    logic [31:0]   r_mem [DEPTH_WORDS] = '{default: '0};
    logic          w_idle, w_aligned, w_vr, w_vw, w_rej, w_acc_w, w_drain, w_cap, w_unused;

    // upper address bits fold out of range addresses back onto the array
    assign w_idx     = i_addr[AW+1:2];
    assign w_unused  = ^i_addr[31:AW+2];
    assign w_aligned = i_addr[1:0] == 2'b00;
    assign w_vr      = i_mem_read & ~i_mem_write & w_aligned;
    assign w_vw      = i_mem_write & ~i_mem_read & w_aligned;
    assign w_rej     = (i_mem_read | i_mem_write) & ~(w_vr | w_vw);
    assign w_idle    = r_state == IDLE;
    assign w_acc_w   = w_idle & w_vw & ~r_wb_valid;
    assign w_drain   = r_wb_valid & (r_wb_cnt == 4'd0);
    assign w_cap_idx = w_idle ? w_idx : r_ridx;

    always_comb begin
        w_next = r_state;
        w_cap  = 1'b0;
        case (r_state)
            IDLE: begin
                w_next = w_vr ? ((W == 4'd0) ? RRESP : RBUSY) : IDLE;
                w_cap  = w_vr & (W == 4'd0);
            end
            RBUSY: begin
                w_next = (r_cnt <= 4'd1) ? RRESP : RBUSY;
                w_cap  = r_cnt <= 4'd1;
            end
            default: w_next = IDLE;
        endcase
    end

    assign o_stall = i_rst & ((r_state == RBUSY) | (w_idle & w_vr) | (w_idle & w_vw & r_wb_valid));
    assign o_ready = r_state == RRESP;
    assign o_err   = r_err;
    assign o_rd    = r_rd;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_ridx     <= '0;
            r_rd       <= '0;
            r_err      <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_cnt   <= '0;
            r_wb_idx   <= '0;
            r_wb_data  <= '0;
        end else begin
            r_state <= w_next;
            r_err   <= w_idle & w_rej;
            if (w_idle & w_vr) begin
                r_ridx <= w_idx;
                r_cnt  <= W;
            end else if (r_state == RBUSY) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // a buffered write to the same word is always newer than the array
            if (w_cap)
                r_rd <= (r_wb_valid && r_wb_idx == w_cap_idx) ? r_wb_data : r_mem[w_cap_idx];
            if (w_acc_w) begin
                r_wb_valid <= 1'b1;
                r_wb_idx   <= w_idx;
                r_wb_data  <= i_wd;
                r_wb_cnt   <= W;
            end else if (w_drain) begin
                r_wb_valid <= 1'b0;
            end else if (r_wb_valid) begin
                r_wb_cnt <= r_wb_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst && w_drain)
            r_mem[r_wb_idx] <= r_wb_data;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized checks of dmem_responder against a
// timestamp-based transaction model (WAIT_CYCLES=2), plus directed WAIT_CYCLES=0 checks.
module tb_dmem_responder;
    localparam int W = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, mr, mw, ready, stall, err;
    logic [31:0] addr, wd, rd;
    logic        rst1, mr1, mw1, ready1, stall1, err1;
    logic [31:0] addr1, wd1, rd1;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W)) dut (
        .i_clk(clk), .i_rst(rst), .i_mem_read(mr), .i_mem_write(mw),
        .i_addr(addr), .i_wd(wd), .o_rd(rd), .o_ready(ready), .o_stall(stall), .o_err(err)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0w (
        .i_clk(clk), .i_rst(rst1), .i_mem_read(mr1), .i_mem_write(mw1),
        .i_addr(addr1), .i_wd(wd1), .o_rd(rd1), .o_ready(ready1), .o_stall(stall1), .o_err(err1)
    );

    int total = 0;
    int bad = 0;

    // Model: a read is in flight from its accept cycle up to rd_at (its ready cycle);
    // a posted write sits in the buffer until it lands at the end of cycle wb_at.
    int          n = 0;
    int          rd_at = -1;
    int          wb_at = 0;
    int          wb_idx = 0;
    bit          wb_pend = 0;
    logic [31:0] wb_dat = 0, rd_val = 0, rd_exp = 0;
    logic        err_exp = 0, last_stall = 0;
    logic [31:0] mem [256];
    logic        s_stall, s_ready, s_err;
    logic [31:0] s_rd;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (cycle %0d): got %h want %h", nm, n, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic m_r, input logic m_w, input logic [31:0] a, input logic [31:0] d);
        bit idle, aligned, vr, vw, rej, acc_r, acc_w, pend0;
        int idx;
        logic e_stall;
        rst = r; mr = m_r; mw = m_w; addr = a; wd = d;
        idle    = n > rd_at;
        aligned = a[1:0] == 2'b00;
        vr      = m_r && !m_w && aligned;
        vw      = m_w && !m_r && aligned;
        rej     = (m_r || m_w) && !(vr || vw);
        idx     = int'((a >> 2) & 32'hFF);
        e_stall = r && ((!idle && n < rd_at) || (idle && vr) || (idle && vw && wb_pend));
        @(negedge clk);
        s_stall = stall; s_ready = ready; s_rd = rd; s_err = err;
        check("stall", stall, e_stall);
        check("ready", ready, n == rd_at);
        check("err", err, err_exp);
        check("rd", rd, rd_exp);
        last_stall = e_stall;
        @(posedge clk);
        if (!r) begin
            rd_at = -1; wb_pend = 0; rd_exp = 0; err_exp = 0;
        end else begin
            err_exp = idle && rej;
            pend0   = wb_pend;
            acc_r   = idle && vr;
            acc_w   = idle && vw && !pend0;
            if (acc_r) begin
                rd_at  = n + W + 1;
                rd_val = (pend0 && wb_idx == idx) ? wb_dat : mem[idx];
            end
            if (n + 1 == rd_at) rd_exp = rd_val;
            if (pend0 && wb_at == n) begin
                mem[wb_idx] = wb_dat;
                wb_pend = 0;
            end
            if (acc_w) begin
                wb_pend = 1; wb_idx = idx; wb_dat = d; wb_at = n + W + 1;
            end
        end
        n++;
        #1;
    endtask

    task automatic cyc1(input logic r, input logic m_r, input logic m_w, input logic [31:0] a, input logic [31:0] d);
        rst1 = r; mr1 = m_r; mw1 = m_w; addr1 = a; wd1 = d;
        @(negedge clk);
        s_stall = stall1; s_ready = ready1; s_rd = rd1; s_err = err1;
        @(posedge clk);
        #1;
    endtask

    logic        cmr, cmw;
    logic [31:0] ca, cd;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst1 = 0; mr1 = 0; mw1 = 0; addr1 = 0; wd1 = 0;
        rst = 0; mr = 1; mw = 0; addr = 32'h10; wd = 0;
        @(posedge clk);
        #1;
        repeat (2) begin
            cyc(0, 1, 0, 32'h10, 0);
            check("t1 stall", s_stall, 0); check("t1 ready", s_ready, 0);
            check("t1 rd", s_rd, 0); check("t1 err", s_err, 0);
        end
        cyc(1, 0, 0, 0, 0);
        // write then read same word: forwarded from the buffer
        cyc(1, 0, 1, 32'h10, 32'hDEADBEEF);
        check("t2 wr stall", s_stall, 0);
        repeat (3) begin
            cyc(1, 1, 0, 32'h10, 0);
            check("t2 rd stall", s_stall, 1);
        end
        cyc(1, 1, 0, 32'h10, 0);
        check("t2 ready", s_ready, 1); check("t2 rd", s_rd, 32'hDEADBEEF); check("t2 stall end", s_stall, 0);
        cyc(1, 0, 0, 0, 0);
        // blocked second write, then aliased read
        cyc(1, 0, 1, 32'h20, 32'h1);
        check("t3 w1 stall", s_stall, 0);
        repeat (3) begin
            cyc(1, 0, 1, 32'h24, 32'h2);
            check("t3 blocked stall", s_stall, 1);
        end
        cyc(1, 0, 1, 32'h24, 32'h2);
        check("t3 w2 accept", s_stall, 0);
        repeat (3) begin
            cyc(1, 1, 0, 32'h424, 0);
            check("t3 rd stall", s_stall, 1);
        end
        cyc(1, 1, 0, 32'h424, 0);
        check("t3 ready", s_ready, 1); check("t3 alias rd", s_rd, 32'h2);
        cyc(1, 0, 0, 0, 0);
        // misaligned read
        cyc(1, 1, 0, 32'h13, 0);
        check("t4 stall", s_stall, 0);
        cyc(1, 0, 0, 0, 0);
        check("t4 err", s_err, 1); check("t4 no ready", s_ready, 0);
        cyc(1, 0, 0, 0, 0);
        check("t4 err once", s_err, 0);
        repeat (3) cyc(1, 1, 0, 32'h10, 0);
        cyc(1, 1, 0, 32'h10, 0);
        check("t4 ready", s_ready, 1); check("t4 rd", s_rd, 32'hDEADBEEF);
        // conflicting request
        cyc(1, 1, 1, 32'h40, 32'hFFFF);
        check("t5 stall", s_stall, 0);
        cyc(1, 0, 0, 0, 0);
        check("t5 err", s_err, 1);
        repeat (3) cyc(1, 1, 0, 32'h40, 0);
        cyc(1, 1, 0, 32'h40, 0);
        check("t5 ready", s_ready, 1); check("t5 rd", s_rd, 0);
        // reset mid-drain discards the buffered write
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 1, 32'h30, 32'h55);
        cyc(0, 0, 0, 0, 0);
        check("t6 rst stall", s_stall, 0);
        cyc(1, 0, 0, 0, 0);
        check("t6 rd after rst", s_rd, 0);
        repeat (3) cyc(1, 1, 0, 32'h30, 0);
        cyc(1, 1, 0, 32'h30, 0);
        check("t6 ready", s_ready, 1); check("t6 rd", s_rd, 0);
        // randomized traffic; requests are held while the model says stall
        cmr = 0; cmw = 0; ca = 0; cd = 0;
        for (int k = 0; k < 3000; k++) begin
            if (!last_stall) begin
                int kind;
                kind = int'($urandom % 10);
                ca = ((($urandom % 4)) << 10) | (($urandom % 8) << 2);
                cd = $urandom;
                cmr = 0; cmw = 0;
                if (kind < 4) cmr = 1;
                else if (kind < 7) cmw = 1;
                else if (kind == 8) begin
                    ca = ca | ($urandom % 3 + 1);
                    cmr = 1'($urandom % 2);
                    cmw = !cmr;
                end else if (kind == 9) begin
                    cmr = 1; cmw = 1;
                end
            end
            cyc(($urandom % 64) != 0, cmr, cmw, ca, cd);
        end
        // WAIT_CYCLES=0 instance
        cyc1(0, 0, 0, 0, 0);
        cyc1(1, 0, 0, 0, 0);
        check("w0 idle ready", s_ready, 0); check("w0 idle rd", s_rd, 0);
        cyc1(1, 0, 1, 32'h8, 32'h77);
        check("w0 wr stall", s_stall, 0);
        cyc1(1, 1, 0, 32'h8, 0);
        check("w0 rd stall", s_stall, 1); check("w0 rd not ready", s_ready, 0);
        cyc1(1, 1, 0, 32'h8, 0);
        check("w0 ready", s_ready, 1); check("w0 rd", s_rd, 32'h77); check("w0 stall end", s_stall, 0);
        cyc1(1, 0, 0, 0, 0);
        check("w0 ready once", s_ready, 0); check("w0 rd held", s_rd, 32'h77);
        cyc1(1, 0, 1, 32'h30, 32'h55);
        cyc1(0, 0, 0, 0, 0);
        check("w0 rst stall", s_stall, 0);
        cyc1(1, 0, 0, 0, 0);
        check("w0 rd cleared", s_rd, 0);
        cyc1(1, 1, 0, 32'h30, 0);
        check("w0 t6 stall", s_stall, 1);
        cyc1(1, 1, 0, 32'h30, 0);
        check("w0 t6 ready", s_ready, 1); check("w0 t6 rd", s_rd, 0);
        cyc1(1, 1, 1, 32'h4, 0);
        cyc1(1, 0, 0, 0, 0);
        check("w0 err", s_err, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder that serves the pipeline's MEM-stage `MemRead`/`MemWrite` requests. It sits on the far side of the CPU data-memory port and replaces the zero-latency array with a word memory that has a configurable read latency. Writes are posted through a one-entry write buffer, and a `stall` output lets the pipeline freeze while a request is outstanding. Read data is forwarded from the buffer when a read hits a pending write.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words. Power of two.
- `WAIT_CYCLES`, default 2: extra latency cycles, range 0..15, held in a 4-bit counter.
- `clk`  in  1  single clock. All state updates on its rising edge.
- `rst`  in  1  reset. Synchronous, active-low.
- `MemRead`  in  1  read request.
- `MemWrite`  in  1  write request.
- `addr`  in  32  byte address. Word index is `addr[AW+1:2]`, where AW = log2(DEPTH_WORDS).
- `wd`  in  32  write data.
- `rd`  out  32  read data. Registered, and held until the next read completes.
- `ready`  out  1  one-cycle pulse: `rd` is valid for the completed read.
- `stall`  out  1  combinational. Pipeline must hold the MEM stage and its request inputs.
- `err`  out  1  registered one-cycle pulse: the request was rejected.

## Operation
- **Read FSM states:** IDLE, RBUSY, RRESP.
- **Write buffer:** `wb_valid`, `wb_idx`, `wb_data`, and drain counter `wb_cnt`.
- **Valid request:** exactly one of `MemRead`/`MemWrite` is high and `addr[1:0]==0`.
- **Rejected requests:**
  - Both `MemRead` and `MemWrite` high, or `addr[1:0]!=0`, while in IDLE.
  - `err`=1 on the next cycle.
  - No state change, no `stall`, no memory update.
- **Address decode:** out-of-range addresses alias by taking the word index modulo DEPTH_WORDS. For example, 0x400 aliases 0x000 at depth 256.
- **Read accept:**
  - Happens in IDLE. Latch the index, load the counter with WAIT_CYCLES.
  - Go to RBUSY if WAIT_CYCLES>0, otherwise go directly to RRESP.
- **RBUSY:** decrement the counter; at 0, go to RRESP.
- **Capturing `rd`:** on the edge entering RRESP, `rd` <= `wb_data` if `wb_valid` and `wb_idx`==read index, else `array[index]`.
- **RRESP:**
  - `ready`=1, `stall`=0.
  - Request inputs seen in this cycle belong to the completed read and are not re-accepted.
  - Next state is IDLE.
- **Write accept:**
  - Happens in IDLE when `wb_valid`==0.
  - Capture index and data, set `wb_valid`, load `wb_cnt`=WAIT_CYCLES. `stall`=0, so the write is posted.
- **Write blocked:** a write in IDLE while `wb_valid`==1 raises `stall` and is not accepted. It is accepted in the first IDLE cycle after `wb_valid` clears.
- **Drain:**
  - `wb_cnt` decrements each cycle while `wb_valid`.
  - On the edge where `wb_cnt`==0, `array[wb_idx]` <= `wb_data` and `wb_valid` clears.
  - Drain proceeds independently of the read FSM: one array write port and one read port.
- **`stall` equation:** `stall` = rst & ((state==RBUSY) | (IDLE & valid read) | (IDLE & valid write & `wb_valid`)).
- **Array contents:**
  - Zero at time 0.
  - Not cleared by reset.
- **Reset (`rst`=0 at a rising edge):**
  - State returns to IDLE; `wb_valid`=0; counters=0.
  - `rd`=0, `ready`=0, `err`=0.
  - A pending buffered write is discarded unwritten; an in-flight read is abandoned.
  - `stall`=0 while `rst`=0.

## Timing
- **Read accepted in cycle T:**
  - `stall`=1 in cycles T..T+WAIT_CYCLES.
  - `ready`=1 and `rd` valid in T+WAIT_CYCLES+1.
  - Earliest next accept is T+WAIT_CYCLES+2.
  - With WAIT_CYCLES=0: `stall` in T only, `ready` in T+1.
- **Write accepted in cycle T:**
  - `wb_valid`=1 in T+1..T+WAIT_CYCLES+1.
  - Array updated at the edge ending T+WAIT_CYCLES+1.
  - Next write is accepted no earlier than T+WAIT_CYCLES+2.
- **Read and drain completing on the same edge:** forwarding from the buffer supplies the new data, so `rd` never returns stale data.
- **Error:** `err` asserts exactly one cycle after the offending request and lasts one cycle.

## Test plan
Unless stated, the bench uses WAIT_CYCLES=2 and DEPTH_WORDS=256.

1. **Reset holds outputs quiet.** Hold `rst`=0 for 2 cycles with `MemRead`=1, `addr`=0x10.
   - Required: `stall`=0, `ready`=0, `rd`=0, `err`=0 throughout.
2. **Read forwarded from the write buffer.** Write 0xDEADBEEF to 0x10 at T, then read 0x10 at T+1.
   - Required: `stall`=0 at T; `stall`=1 at T+1..T+3; `ready`=1 with `rd`=0xDEADBEEF at T+4.
3. **Blocked write and aliasing.** Back-to-back writes 0x20←0x1 at T and 0x24←0x2 at T+1, then read 0x424 at T+5.
   - Required: `stall`=1 at T+1..T+3; second write accepted at T+4.
   - Read of 0x424 aliases 0x024 and returns `rd`=0x2 at T+8.
4. **Misaligned read.** Read 0x13.
   - Required: `err`=1 for one cycle at T+1; `stall`=0; no `ready`.
   - A subsequent read of 0x10 is unaffected.
5. **Conflicting request.** `MemRead`=`MemWrite`=1, `addr`=0x40, `wd`=0xFFFF.
   - Required: `err` pulse; a later read of 0x40 returns 0.
6. **Reset mid-drain.** Write 0x30←0x55 at T; drive `rst`=0 at the T+1 edge; release; read 0x30.
   - Required: `rd`=0 (write discarded).
   - Repeat with WAIT_CYCLES=0: a read accepted at T gives `ready` at T+1.
